vga_draw_arbiter: RTL and testbench
===================================

Name: vga_draw_arbiter

Overview:
- Shares the single vga_adapter plot port between NUM_ENG drawing engines, such as fillscreen, circle and reuleaux.
- Each engine raises a request. The arbiter grants engines round-robin, one at a time.
- It drives the granted engine's start/done handshake and forwards that engine's pixel stream, registered, to the adapter.
- It sits in the top level between the engines and vga_adapter, replacing direct engine-to-adapter wiring.

Parameters:
NUM_ENG, 3, number of engines (2..8); sets port vector widths.
TIMEOUT, 32'd20000, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
clk  input  1  system clock (CLOCK_50 domain)
rst  input  1  synchronous reset, active-high
req  input  NUM_ENG  per-engine draw request; level, held until granted
start  output  NUM_ENG  one-hot start to the granted engine; held until that engine's done
done  input  NUM_ENG  per-engine done level from each engine
eng_x  input  NUM_ENG*8  packed engine x; engine i at bits [8i+7:8i]
eng_y  input  NUM_ENG*7  packed engine y; engine i at bits [7i+6:7i]
eng_colour  input  NUM_ENG*3  packed engine colour
eng_plot  input  NUM_ENG  per-engine plot strobe
vga_x  output  8  to adapter x
vga_y  output  7  to adapter y
vga_colour  output  3  to adapter colour
vga_plot  output  1  to adapter plot
grant  output  NUM_ENG  one-hot current owner; 0 when idle
busy  output  1  high in START, RUN and RELEASE
timeout  output  1  one-cycle pulse on watchdog abort; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- All outputs are registered. Reset is synchronous and active-high.
- Reset values:
  - start, grant, vga_x, vga_y, vga_colour, vga_plot, busy and timeout are 0.
  - State is IDLE.
  - The last-owner pointer is NUM_ENG-1, so engine 0 wins first.
- Reset mid-operation aborts immediately: the next cycle shows reset values, with no RELEASE cycle.
- IDLE:
  - start=0 and vga_plot=0.
  - If req is nonzero, pick the first set bit searching upward from last+1, wrapping modulo NUM_ENG.
  - Register the winner into grant and go to START.
  - If req is zero, stay in IDLE.
- START (1 cycle): start[g]=1 and busy=1; go to RUN. This cycle absorbs an engine that registers start.
- RUN:
  - start[g] stays at 1.
  - Each cycle: vga_x/y/colour <= eng_*[g] and vga_plot <= eng_plot[g]. This gives 1-cycle latency from engine to adapter.
  - When done[g]=1, go to RELEASE. The plot presented in that same cycle is still forwarded.
- RELEASE (1 cycle):
  - start=0 and vga_plot=0; grant is held.
  - last <= g. Then go to IDLE, where grant clears.
- Job spacing: done seen at cycle t gives RELEASE at t+1, IDLE/arbitration at t+2, and the next start at t+4. Minimum engine-to-engine gap is 3 start-low cycles.
- Signals from non-granted engines are ignored: their eng_plot, eng_* and done have no effect.
- req of the owner is ignored after grant; only done ends the job.
- A req that drops before being granted is simply not served.
- With a single requester, that engine is re-granted back-to-back.
- done already high at START (a stale done) is not honoured until RUN. This guarantees at least one start-high RUN cycle.
- Coordinates are passed through unmodified; no range checking.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT-1 with no done[g], go to RELEASE and pulse timeout=1 for one cycle, coincident with RELEASE.
  - The pointer advances as on a normal completion.
- When undefined: no counter is synthesized, timeout is tied to 0, and RUN waits indefinitely for done.

Test Plan:
1. Reset, then req=3'b111 → grant order 001, 010, 100, 001. Each start stays high until its done; there are 3 start-low cycles between jobs.
2. Only req[1]=1; engine 1 gives plot for 4 cycles at x=10..13, y=5, colour=3'b010, then done → vga outputs show the same values one cycle later, and vga_plot is high for exactly 4 cycles.
3. Engine 2 not granted drives eng_plot=1, x=99; engine 0 owns → vga_x never equals 99, and vga_plot follows only eng_plot[0].
4. Assert rst mid-RUN of engine 1 → next cycle start=0, grant=0, vga_plot=0, busy=0. With req=3'b011 afterwards, engine 0 is granted first.
5. Engine 0 holds done=1 from the previous job when granted → start[0] is high for at least START+1 RUN cycles, then RELEASE.
6. Under ARB_TIMEOUT_EN with TIMEOUT=16, engine 0 never asserts done → timeout pulses once 16 cycles after RUN entry and start[0] drops. A pending req[1] is granted next.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing the vga_adapter plot port between NUM_ENG drawing engines.
// Optional watchdog abort of a stuck engine is built when ARB_TIMEOUT_EN is defined.
module vga_draw_arbiter #(
    parameter int          NUM_ENG = 3,
    parameter logic [31:0] TIMEOUT = 32'd20000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_ENG-1:0]     req,
    output logic [NUM_ENG-1:0]     start,
    input  logic [NUM_ENG-1:0]     done,
    input  logic [NUM_ENG*8-1:0]   eng_x,
    input  logic [NUM_ENG*7-1:0]   eng_y,
    input  logic [NUM_ENG*3-1:0]   eng_colour,
    input  logic [NUM_ENG-1:0]     eng_plot,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic [NUM_ENG-1:0]     grant,
    output logic                   busy,
    output logic                   timeout
);

    localparam int IW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        RELEASE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IW-1:0]       last;
    logic [IW-1:0]       gidx;
    logic [IW-1:0]       win_idx;
    logic                win_found;
    logic [NUM_ENG-1:0]  win_onehot;
    logic                owner_done;
    logic                wd_expired;

    logic [7:0]          x_arr      [NUM_ENG];
    logic [6:0]          y_arr      [NUM_ENG];
    logic [2:0]          colour_arr [NUM_ENG];

    always_comb begin
        for (int i = 0; i < NUM_ENG; i++) begin
            x_arr[i]      = eng_x[8*i +: 8];
            y_arr[i]      = eng_y[7*i +: 7];
            colour_arr[i] = eng_colour[3*i +: 3];
        end
    end

    assign owner_done = done[gidx];

    // Search upward from the engine after the last owner, wrapping at NUM_ENG.
    always_comb begin
        logic [IW:0] cand;
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_ENG; k++) begin
            cand = {1'b0, last} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_ENG))
                cand = cand - (IW+1)'(NUM_ENG);
            if (!win_found && req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    assign win_onehot = {{(NUM_ENG-1){1'b0}}, 1'b1} << win_idx;

    // A done already high during START is deliberately ignored until RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_found) state_next = START;
            START:   state_next = RUN;
            RUN:     if (owner_done || wd_expired) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= IW'(NUM_ENG - 1);
            gidx       <= '0;
            grant      <= '0;
            start      <= '0;
            busy       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            state    <= state_next;
            start    <= '0;
            vga_plot <= 1'b0;
            busy     <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gidx  <= win_idx;
                        grant <= win_onehot;
                    end else begin
                        grant <= '0;
                    end
                end
                START: begin
                    start <= grant;
                end
                RUN: begin
                    vga_x      <= x_arr[gidx];
                    vga_y      <= y_arr[gidx];
                    vga_colour <= colour_arr[gidx];
                    vga_plot   <= eng_plot[gidx];
                    if (state_next == RUN)
                        start <= grant;
                end
                RELEASE: begin
                    last  <= gidx;
                    grant <= '0;
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [31:0] wd_count;

    assign wd_expired = (state == RUN) && (wd_count == TIMEOUT - 32'd1);

    // The pulse lines up with the RELEASE cycle of an aborted job.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_count <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= (state == RUN) && (state_next == RELEASE) && !owner_done;
            if (state == START)
                wd_count <= '0;
            else if (state == RUN)
                wd_count <= wd_count + 32'd1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Table-driven bench for vga_draw_arbiter with three engines and a 16-cycle watchdog.
module tb_vga_draw_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  start;
    logic [2:0]  done;
    logic [23:0] eng_x;
    logic [20:0] eng_y;
    logic [8:0]  eng_colour;
    logic [2:0]  eng_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [2:0]  grant;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    vga_draw_arbiter #(
        .NUM_ENG (3),
        .TIMEOUT (32'd16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .start      (start),
        .done       (done),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_colour (eng_colour),
        .eng_plot   (eng_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .grant      (grant),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [2:0]  done;
        logic [2:0]  plot;
        logic [23:0] ex;
        logic [20:0] ey;
        logic [8:0]  ec;
        logic [7:0]  exp_ctl;
        logic        chk;
        logic [7:0]  exp_x;
        logic [6:0]  exp_y;
        logic [2:0]  exp_c;
    } vec_t;

    vec_t        tbl[$];
    logic [23:0] px;
    logic [20:0] py;
    logic [8:0]  pc;

    // exp_ctl packs {start, grant, busy, vga_plot} as seen after the clock edge.
    function automatic vec_t row(input logic r, input logic [2:0] rq, input logic [2:0] dn,
                                 input logic [2:0] pl, input logic [2:0] st, input logic [2:0] gr,
                                 input logic bz, input logic vp);
        vec_t v;
        v.rst     = r;
        v.req     = rq;
        v.done    = dn;
        v.plot    = pl;
        v.ex      = px;
        v.ey      = py;
        v.ec      = pc;
        v.exp_ctl = {st, gr, bz, vp};
        v.chk     = 1'b0;
        v.exp_x   = '0;
        v.exp_y   = '0;
        v.exp_c   = '0;
        return v;
    endfunction

    function automatic vec_t rowd(input logic r, input logic [2:0] rq, input logic [2:0] dn,
                                  input logic [2:0] pl, input logic [2:0] st, input logic [2:0] gr,
                                  input logic bz, input logic vp, input logic [7:0] x,
                                  input logic [6:0] y, input logic [2:0] c);
        vec_t v;
        v       = row(r, rq, dn, pl, st, gr, bz, vp);
        v.chk   = 1'b1;
        v.exp_x = x;
        v.exp_y = y;
        v.exp_c = c;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        rst        = v.rst;
        req        = v.req;
        done       = v.done;
        eng_plot   = v.plot;
        eng_x      = v.ex;
        eng_y      = v.ey;
        eng_colour = v.ec;
        step();
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checks++;
        if ({start, grant, busy, vga_plot} !== v.exp_ctl) begin
            errors++;
            $display("[TB] FAIL row%0d ctl {start,grant,busy,plot} got %b want %b",
                     idx, {start, grant, busy, vga_plot}, v.exp_ctl);
        end
        if (v.chk) begin
            checks++;
            if ({vga_x, vga_y, vga_colour} !== {v.exp_x, v.exp_y, v.exp_c}) begin
                errors++;
                $display("[TB] FAIL row%0d pixel got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b",
                         idx, vga_x, vga_y, vga_colour, v.exp_x, v.exp_y, v.exp_c);
            end
        end
    endtask

    initial begin
        px = {8'd99, 8'd7, 8'd32};
        py = {7'd9, 7'd5, 7'd3};
        pc = {3'b111, 3'b010, 3'b101};

        // round robin with all three requesting
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b001, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b110, 3'b000, 3'b001, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b001, 3'b000, 3'b000, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0));
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b010, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b010, 3'b010, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b010, 3'b000, 3'b000, 3'b010, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0));
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b100, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b100, 3'b100, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b100, 3'b000, 3'b000, 3'b100, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0));
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 3'b001, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0));
        tbl.push_back(row(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0));

        // engine 1 streams four pixels, output one cycle behind
        tbl.push_back(row(0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 1, 0));
        tbl.push_back(row(0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 1, 0));
        px = {8'd99, 8'd10, 8'd32};
        tbl.push_back(rowd(0, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 1, 1, 8'd10, 7'd5, 3'b010));
        px = {8'd99, 8'd11, 8'd32};
        tbl.push_back(rowd(0, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 1, 1, 8'd11, 7'd5, 3'b010));
        px = {8'd99, 8'd12, 8'd32};
        tbl.push_back(rowd(0, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 1, 1, 8'd12, 7'd5, 3'b010));
        px = {8'd99, 8'd13, 8'd32};
        tbl.push_back(rowd(0, 3'b000, 3'b010, 3'b010, 3'b000, 3'b010, 1, 1, 8'd13, 7'd5, 3'b010));
        tbl.push_back(row(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0));
        tbl.push_back(row(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0));

        // engine 0 owns while engine 2 plots x=99 in the background
        px = {8'd99, 8'd7, 8'd32};
        tbl.push_back(row(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 1, 0));
        px = {8'd99, 8'd7, 8'd40};
        tbl.push_back(rowd(0, 3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 1, 0, 8'd40, 7'd3, 3'b101));
        px = {8'd99, 8'd7, 8'd41};
        tbl.push_back(rowd(0, 3'b000, 3'b000, 3'b101, 3'b001, 3'b001, 1, 1, 8'd41, 7'd3, 3'b101));
        px = {8'd99, 8'd7, 8'd42};
        tbl.push_back(rowd(0, 3'b000, 3'b000, 3'b110, 3'b001, 3'b001, 1, 0, 8'd42, 7'd3, 3'b101));
        px = {8'd99, 8'd7, 8'd43};
        tbl.push_back(rowd(0, 3'b000, 3'b101, 3'b001, 3'b000, 3'b001, 1, 1, 8'd43, 7'd3, 3'b101));
        tbl.push_back(row(0, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 0, 0));

        // stale done held through START still yields a RUN cycle with start high
        tbl.push_back(row(0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b000, 3'b001, 3'b000, 3'b001, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0));

        // reset in the middle of engine 1's job, then engine 0 wins again
        tbl.push_back(row(0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 1, 0));
        tbl.push_back(row(0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 1, 0));
        tbl.push_back(row(0, 3'b010, 3'b000, 3'b010, 3'b010, 3'b010, 1, 1));
        tbl.push_back(rowd(1, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0, 8'd0, 7'd0, 3'b000));
        tbl.push_back(row(0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 1, 0));
        tbl.push_back(row(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0));

        rst        = 1'b1;
        req        = '0;
        done       = '0;
        eng_plot   = '0;
        eng_x      = px;
        eng_y      = py;
        eng_colour = pc;
        step();
        step();
        checkValue("reset_ctl", {29'd0, start, grant, busy, vga_plot, timeout}, 32'd0);
        checkValue("reset_pixel", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
        rst = 1'b0;
        step();
        checkValue("idle_no_req", {28'd0, grant, busy}, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(i, tbl[i]);
        end

        // engine 0 never finishes while engine 1 waits
        rst      = 1'b0;
        req      = 3'b001;
        done     = 3'b000;
        eng_plot = 3'b000;
        step();
        checkValue("wd_grant0", {29'd0, grant}, 32'd1);
        req = 3'b010;
        step();
        checkValue("wd_run_entry", {28'd0, start, timeout}, {28'd0, 4'b0010});
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            step();
            checkValue("wd_run", {28'd0, start, timeout}, {28'd0, 4'b0010});
        end
        step();
        checkValue("wd_fire", {25'd0, start, timeout, grant}, {25'd0, 7'b0001001});
        step();
        checkValue("wd_pulse_end", {27'd0, timeout, grant, busy}, 32'd0);
        step();
        checkValue("wd_next_grant", {29'd0, grant}, 32'd2);
`else
        for (int k = 1; k <= 40; k++) begin
            step();
            checkValue("no_wd_run", {28'd0, start, timeout}, {28'd0, 4'b0010});
        end
        done = 3'b001;
        step();
        checkValue("no_wd_release", {26'd0, start, grant}, {26'd0, 6'b000001});
        done = 3'b000;
        step();
        checkValue("no_wd_idle", {28'd0, grant, busy}, 32'd0);
        step();
        checkValue("no_wd_next_grant", {29'd0, grant}, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
